spi_req_arbiter: RTL

Shares the single SPI shift/bit-count engine between N_REQ requesters.
- Round-robin arbitration among requesters.
- Latches the winner's data and sequences the engine with a one-cycle start pulse.
- Waits for the engine's one-cycle finish pulse, then returns a done pulse to the winner.
- Sits between client blocks (config loaders, sensor pollers) and the engine, whose start input and finish output it drives and consumes.

---
 rtl/spi_arb_pkg.sv | 15 +
 rtl/spi_rr_pick.sv | 29 ++
 rtl/spi_req_arbiter.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/spi_arb_pkg.sv
// Shared types and defaults for the SPI request arbiter.
// State encoding plus default word and watchdog widths.
package spi_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_START = 2'b01,
    ST_WAIT  = 2'b10,
    ST_DONE  = 2'b11
  } arb_state_e;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_TO_W   = 8;

endpackage

// File: rtl/spi_rr_pick.sv
// Combinational round-robin picker: searches ptr+1, ptr+2, ...
// Ports: req, ptr in; valid (any req) and winner index out.
module spi_rr_pick #(
  parameter int N_REQ = 4,
  parameter int IDX_W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic             valid,
  output logic [IDX_W-1:0] winner
);

  logic [IDX_W-1:0] idx;

  // Walk from the farthest candidate to the nearest so the
  // nearest requesting index is the last (winning) assignment.
  always_comb begin
    valid  = |req;
    winner = '0;
    idx    = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      idx = IDX_W'((int'(ptr) + k) % N_REQ);
      if (req[idx]) begin
        winner = idx;
      end
    end
  end

endmodule

// File: rtl/spi_req_arbiter.sv
// Round-robin arbiter sharing one SPI engine among N_REQ clients.
// Ports: clk, reset (async high), req/req_data in; grant/done/err,
// eng_start/eng_data/eng_sel/eng_abort out; eng_fin in; busy out.
// Optional watchdog: define SPI_ARB_TIMEOUT_EN.
module spi_req_arbiter
  import spi_arb_pkg::*;
#(
  parameter int N_REQ  = 4,
  parameter int DATA_W = DEF_DATA_W,
  parameter int IDX_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1,
  parameter int TO_W   = DEF_TO_W
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  output logic [N_REQ-1:0]        grant,
  output logic [N_REQ-1:0]        done,
  output logic                    err,
  output logic                    eng_start,
  output logic [DATA_W-1:0]       eng_data,
  output logic [IDX_W-1:0]        eng_sel,
  output logic                    eng_abort,
  input  logic                    eng_fin,
  output logic                    busy
);

  arb_state_e        state_q, state_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [IDX_W-1:0]  sel_q, sel_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              err_q, err_d;
  logic              pick_valid;
  logic [IDX_W-1:0]  pick_idx;
  logic [N_REQ-1:0]  sel_oh;

  spi_rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req    (req),
    .ptr    (ptr_q),
    .valid  (pick_valid),
    .winner (pick_idx)
  );

`ifdef SPI_ARB_TIMEOUT_EN
  // Last WAIT count before the watchdog would reach all-ones.
  localparam logic [TO_W-1:0] WD_LAST = {{(TO_W-1){1'b1}}, 1'b0};
  logic [TO_W-1:0] wd_q, wd_d;
`endif

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    data_d  = data_q;
    err_d   = err_q;
`ifdef SPI_ARB_TIMEOUT_EN
    wd_d    = wd_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        err_d = 1'b0;
        if (pick_valid) begin
          sel_d   = pick_idx;
          data_d  = req_data[pick_idx*DATA_W +: DATA_W];
          state_d = ST_START;
        end
      end
      ST_START: begin
        state_d = ST_WAIT;
`ifdef SPI_ARB_TIMEOUT_EN
        wd_d    = '0;
`endif
      end
      ST_WAIT: begin
        if (eng_fin) begin
          state_d = ST_DONE;
`ifdef SPI_ARB_TIMEOUT_EN
        end else if (wd_q == WD_LAST) begin
          state_d = ST_DONE;
          err_d   = 1'b1;
        end else begin
          wd_d = wd_q + 1'b1;
`endif
        end
      end
      ST_DONE: begin
        ptr_d   = sel_q;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      ptr_q   <= IDX_W'(N_REQ - 1);
      sel_q   <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

`ifdef SPI_ARB_TIMEOUT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wd_q <= '0;
    end else begin
      wd_q <= wd_d;
    end
  end

  // Abort and err both mark the DONE cycle of a timed-out transfer.
  assign eng_abort = (state_q == ST_DONE) & err_q;
  assign err       = (state_q == ST_DONE) & err_q;
`else
  localparam logic [TO_W-1:0] WD_NONE = '0;

  // No watchdog: err_q never sets, abort is constant low.
  assign eng_abort = |WD_NONE;
  assign err       = (state_q == ST_DONE) & err_q;
`endif

  always_comb begin
    sel_oh         = '0;
    sel_oh[sel_q]  = 1'b1;
  end

  assign eng_start = (state_q == ST_START);
  assign busy      = (state_q != ST_IDLE);
  assign eng_sel   = sel_q;
  assign eng_data  = data_q;
  assign grant     = (state_q == ST_START || state_q == ST_WAIT)
                     ? sel_oh : '0;
  assign done      = (state_q == ST_DONE) ? sel_oh : '0;

endmodule
